// File: rtl/add_pipe_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
package add_pipe_pkg;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefStages = 4;

  function automatic int unsigned calc_cw(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

endpackage

// File: rtl/add_pipe_nbit_if.sv
// Operand/result handshake bundle for add_pipe_nbit; slave is the adder side.
interface add_pipe_nbit_if #(
  parameter int unsigned WIDTH = add_pipe_pkg::DefWidth
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_overflow;

  modport slave (
    input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_overflow
  );

  modport master (
    output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_overflow
  );
endinterface

// File: rtl/add_chunk.sv
// Combinational ripple adder for one chunk; also exposes the carry into its MSB.
module add_chunk #(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          c_i,
  output logic [CW-1:0] s_o,
  output logic          c_o,
  output logic          c_msb_o
);

  always_comb begin
    logic carry;
    carry   = c_i;
    s_o     = '0;
    c_msb_o = 1'b0;
    for (int i = 0; i < int'(CW); i++) begin
      if (i == int'(CW) - 1) c_msb_o = carry;
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/add_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit chunk per stage, global-stall handshake.
module add_pipe_nbit
  import add_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages
) (
  input logic             i_clk,
  input logic             i_rst,
  add_pipe_nbit_if.slave  bus
);

  localparam int unsigned CW = calc_cw(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : gen_param_check
    $error("add_pipe_nbit: STAGES must be >= 1 and divide WIDTH");
  end

  logic [STAGES-1:0] valid_q, carry_q;
  logic [STAGES-1:0] v_src, c_src, cout, cmsb;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  sum_src [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [CW-1:0]     chunk_sum [STAGES];
  logic              ovf_q;
  logic              adv;

  assign adv = !valid_q[STAGES-1] || bus.i_ready;

  for (genvar s = 0; s < STAGES; s++) begin : gen_stage
    if (s == 0) begin : gen_head
      // Subtract folds into add: invert B once here and force carry-in to 1.
      assign a_src[0]   = bus.i_a;
      assign b_src[0]   = bus.i_sub ? ~bus.i_b : bus.i_b;
      assign c_src[0]   = bus.i_sub | bus.i_cin;
      assign sum_src[0] = '0;
      assign v_src[0]   = bus.i_valid;
    end else begin : gen_body
      assign a_src[s]   = a_q[s-1];
      assign b_src[s]   = b_q[s-1];
      assign c_src[s]   = carry_q[s-1];
      assign sum_src[s] = sum_q[s-1];
      assign v_src[s]   = valid_q[s-1];
    end

    add_chunk #(
      .CW(CW)
    ) u_chunk (
      .a_i     (a_src[s][s*CW +: CW]),
      .b_i     (b_src[s][s*CW +: CW]),
      .c_i     (c_src[s]),
      .s_o     (chunk_sum[s]),
      .c_o     (cout[s]),
      .c_msb_o (cmsb[s])
    );

    assign sum_d[s] = sum_src[s] | (WIDTH'(chunk_sum[s]) << (s * CW));
  end

  // Data registers load only for valid slots so outputs hold across bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int s = 0; s < int'(STAGES); s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
    end else if (adv) begin
      valid_q <= v_src;
      for (int s = 0; s < int'(STAGES); s++) begin
        if (v_src[s]) begin
          a_q[s]     <= a_src[s];
          b_q[s]     <= b_src[s];
          sum_q[s]   <= sum_d[s];
          carry_q[s] <= cout[s];
        end
      end
      if (v_src[STAGES-1]) ovf_q <= cmsb[STAGES-1] ^ cout[STAGES-1];
    end
  end

  assign bus.o_ready    = adv;
  assign bus.o_valid    = valid_q[STAGES-1];
  assign bus.o_sum      = sum_q[STAGES-1];
  assign bus.o_carry    = carry_q[STAGES-1];
  assign bus.o_overflow = ovf_q;

  // Last-stage operands and lower-stage MSB carries have no consumer.
  logic unused_bits;
  assign unused_bits = ^{cmsb, a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_add_pipe_nbit.sv
// Scoreboard bench for add_pipe_nbit (WIDTH=16, STAGES=4): directed vectors, stall, reset, random.
module tb_add_pipe_nbit;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [17:0] exp;   // {carry, overflow, sum}
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_pipe_nbit_if #(.WIDTH(W)) bus ();

  add_pipe_nbit #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  vec_t        vecs[10];
  logic [17:0] sb[$];
  int          checks  = 0;
  int          errors  = 0;
  int          out_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [17:0] held;
  logic        rand_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] full;
    logic [15:0] be;
    logic        ovf;
    be   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + 17'(sub ? 1'b1 : cin);
    ovf  = (a[15] == be[15]) && (full[15] != a[15]);
    return {full[16], ovf, full[15:0]};
  endfunction

  task automatic send(input vec_t v);
    int t;
    bus.i_a     = v.a;
    bus.i_b     = v.b;
    bus.i_cin   = v.cin;
    bus.i_sub   = v.sub;
    bus.i_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.o_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=o_ready_low exp=o_ready_high at %0t", $time);
      bus.i_valid = 1'b0;
    end else begin
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: handshake rule, stall stability, in-order result comparison.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      check("ready_rule", bus.o_ready, !bus.o_valid || bus.i_ready);
      if (hold_pend)
        check("stall_hold", {bus.o_valid, bus.o_carry, bus.o_overflow, bus.o_sum}, {1'b1, held});
      hold_pend = bus.o_valid && !bus.i_ready;
      held      = {bus.o_carry, bus.o_overflow, bus.o_sum};
      if (bus.o_valid && bus.i_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got=%h exp=none at %0t", held, $time);
        end else begin
          check("result", held, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   base;
    vec_t rv;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}};
    vecs[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556}};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}};
    vecs[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0002}};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 1'b0, 16'hFFFF}};
    vecs[8] = '{16'h0010, 16'h0010, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0000}};
    vecs[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000}};

    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_cin   = 1'b0;
    bus.i_sub   = 1'b0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("reset_valid", bus.o_valid, 0);
    check("reset_outputs", {bus.o_carry, bus.o_overflow, bus.o_sum}, 0);
    check("reset_ready", bus.o_ready, 1);
    @(posedge clk);
    #1;

    // Single op: latency measured in cycles after the transfer edge.
    send(vecs[0]);
    lat = 0;
    while (!bus.o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, S);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back stream with a three-cycle downstream stall.
    send(vecs[1]);
    fork
      begin
        for (int i = 2; i < 10; i++) send(vecs[i]);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_ready_low", bus.o_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight; the op offered during reset must be dropped.
    for (int i = 0; i < 3; i++) send(vecs[i]);
    rst         = 1'b1;
    bus.i_a     = vecs[3].a;
    bus.i_b     = vecs[3].b;
    bus.i_cin   = vecs[3].cin;
    bus.i_sub   = vecs[3].sub;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    sb.delete();
    base = out_cnt;
    @(negedge clk);
    check("rst_mid_valid", bus.o_valid, 0);
    check("rst_mid_outputs", {bus.o_carry, bus.o_overflow, bus.o_sum}, 0);
    check("rst_mid_ready", bus.o_ready, 1);
    repeat (12) @(negedge clk);
    check("no_stale_results", out_cnt - base, 0);
    @(posedge clk);
    #1;

    // Random traffic against the reference model.
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          rv.a   = 16'($urandom);
          rv.b   = 16'($urandom);
          rv.cin = 1'($urandom_range(1));
          rv.sub = 1'($urandom_range(1));
          rv.exp = model(rv.a, rv.b, rv.cin, rv.sub);
          send(rv);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.i_ready = ($urandom_range(3) != 0);
        end
      end
    join
    bus.i_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
